// File: rtl/dmem_responder.sv
// Data-memory target: single outstanding load/store against a 64-bit word store,
// with byte-lane write masks and a fixed response latency.
module dmem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000000080000000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             wr_q;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [7:0]       wmask_q;
    logic [63:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             access;

    logic [63:0] mem [DEPTH_WORDS];

    // BASE_ADDR is word aligned, so a full-width compare matches the aligned-down address.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
        idx      = offset[IDX_W+2:3];
        access   = (state == S_WAIT) && (cnt == 4'd0);
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= S_RESP;
                        resp_err   <= !in_range;
                        resp_rdata <= (in_range && !wr_q) ? mem[idx] : 64'd0;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_rdata <= 64'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request fields are captured once at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    // A reset landing on the commit edge discards the store.
    always_ff @(posedge clk) begin
        if (!rst && access && wr_q && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic compared against an array-based memory model.
module tb_dmem_responder;

    localparam logic [63:0] BASE  = 64'h0000000080000000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'(32'((a - BASE) >> 3));
    endfunction

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_wmask = 8'($urandom);
    endtask

    // One complete transaction; hold = cycles of resp_ready low once the response is up.
    task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m, input int hold,
                        output logic [63:0] rd, output logic er);
        logic [63:0] exp_d;
        logic        exp_e;
        int          lat;
        check64("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req();
        if (hold > 0) resp_ready = 1'b0;

        exp_e = !addr_ok(a);
        exp_d = 64'd0;
        if (!exp_e) begin
            if (w) begin
                for (int i = 0; i < 8; i++)
                    if (m[i]) ref_mem[word_of(a)][8*i +: 8] = d[8*i +: 8];
            end else begin
                exp_d = ref_mem[word_of(a)];
            end
        end

        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check64("latency", 64'(lat), 64'(LAT));
        check64("rdata", resp_rdata, exp_d);
        check64("err", 64'(resp_err), 64'(exp_e));
        rd = resp_rdata;
        er = resp_err;

        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check64("bp_valid", 64'(resp_valid), 64'd1);
            check64("bp_rdata", resp_rdata, exp_d);
            check64("bp_err", 64'(resp_err), 64'(exp_e));
            check64("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check64("post_valid", 64'(resp_valid), 64'd0);
        check64("post_req_ready", 64'(req_ready), 64'd1);
        check64("post_rdata", resp_rdata, 64'd0);
        check64("post_err", 64'(resp_err), 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] addrs [4];
        logic [63:0] expq [$];
        logic [63:0] a;
        int          n_acc, n_resp, cyc, last_acc, r;
        bit          acc_now;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        req_wmask  = 8'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check64("rst_req_ready", 64'(req_ready), 64'd1);
        check64("rst_resp_valid", 64'(resp_valid), 64'd0);
        check64("rst_rdata", resp_rdata, 64'd0);
        check64("rst_err", 64'(resp_err), 64'd0);
        rst = 1'b0;

        // Fill the whole store so every later load has a defined model value.
        for (int i = 0; i < DEPTH; i++)
            xact(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0, rd, er);

        xact(1'b1, 64'h80001000, 64'h1234567887654321, 8'hFF, 0, rd, er);
        xact(1'b0, 64'h80001000, 64'd0, 8'h00, 0, rd, er);
        check64("full_store_load", rd, 64'h1234567887654321);

        xact(1'b1, 64'h80000800, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 0, rd, er);
        xact(1'b1, 64'h80000800, 64'h1122334455667788, 8'h03, 0, rd, er);
        xact(1'b0, 64'h80000800, 64'd0, 8'h00, 0, rd, er);
        check64("mask_03", rd, 64'hAAAAAAAAAAAA7788);
        xact(1'b1, 64'h80000800, 64'h1122334455667788, 8'h3C, 0, rd, er);
        xact(1'b0, 64'h80000800, 64'd0, 8'h00, 0, rd, er);
        check64("mask_3c", rd, 64'hAAAA334455667788);
        xact(1'b1, 64'h80000800, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, rd, er);
        check64("mask_00_err", 64'(er), 64'd0);
        xact(1'b0, 64'h80000800, 64'd0, 8'h00, 0, rd, er);
        check64("mask_00_nochange", rd, 64'hAAAA334455667788);

        xact(1'b0, 64'h80001000, 64'd0, 8'h00, 5, rd, er);

        xact(1'b0, 64'h7FFFFFF8, 64'd0, 8'h00, 0, rd, er);
        check64("below_base_err", 64'(er), 64'd1);
        check64("below_base_rdata", rd, 64'd0);
        xact(1'b1, 64'h80002000, 64'h5555555555555555, 8'hFF, 0, rd, er);
        check64("past_end_err", 64'(er), 64'd1);
        xact(1'b0, 64'h80000000, 64'd0, 8'h00, 0, rd, er);
        xact(1'b0, 64'h80001FF8, 64'd0, 8'h00, 0, rd, er);
        check64("last_word_err", 64'(er), 64'd0);

        // Store accepted, then reset while it is still waiting: nothing commits.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h80000010;
        req_wdata = 64'h00000000DEADBEEF;
        req_wmask = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check64("wait_rst_req_ready", 64'(req_ready), 64'd1);
        for (int k = 0; k < LAT + 3; k++) begin
            check64("wait_rst_no_resp", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        xact(1'b0, 64'h80000010, 64'd0, 8'h00, 0, rd, er);

        // Back-to-back loads with req_valid held high.
        for (int i = 0; i < 4; i++)
            addrs[i] = BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
        n_acc    = 0;
        n_resp   = 0;
        cyc      = 0;
        last_acc = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addrs[0];
        while (n_resp < 4 && cyc < 100) begin
            acc_now = req_valid && req_ready;
            check64("b2b_overlap", 64'(req_ready & resp_valid), 64'd0);
            if (resp_valid && resp_ready) begin
                check64("b2b_rdata", resp_rdata, expq.pop_front());
                n_resp++;
            end
            if (acc_now) begin
                if (n_acc > 0) check64("b2b_spacing", 64'(cyc - last_acc), 64'(LAT + 2));
                last_acc = cyc;
                expq.push_back(ref_mem[word_of(req_addr)]);
                n_acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                if (n_acc < 4) req_addr = addrs[n_acc];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check64("b2b_responses", 64'(n_resp), 64'd4);

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                a = BASE - 64'(8 * $urandom_range(1, 4));
            else if (r == 1)
                a = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 3));
            else
                a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
            xact(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory request interface. The core is the initiator; this block is the target.
- Accepts one read or write request at a time over a valid/ready handshake and holds a word-addressed 64-bit backing store.
- Applies per-byte write masks and returns read data after a fixed, parameterised latency.
- Replaces the DPI pmem model for synthesizable and self-contained simulation.

Parameters:
- BASE_ADDR, 64'h0000000080000000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 64-bit words in the store (power of two).
- LATENCY, 2, WAIT cycles between accept and response; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  64  byte address; bits [2:0] ignored (word-aligned down)
- req_wdata  input  64  store data
- req_wmask  input  8  byte enables; bit i writes byte lane i (bits [8i+7:8i])
- resp_valid  output  1  response present
- resp_ready  input  1  initiator accepts response
- resp_rdata  output  64  load data; 0 for stores and errors
- resp_err  output  1  address outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state changes on the rising edge of clk.
- Reset values:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch write/addr/wdata/wmask, load counter = LATENCY-1, go to WAIT.
- WAIT:
  - req_ready = 0.
  - If counter != 0, decrement.
  - If counter == 0, perform the access at this edge and go to RESP.
- Access rules:
  - index = (addr - BASE_ADDR) >> 3, 64-bit subtraction.
  - Out of range (addr < BASE_ADDR or index >= DEPTH_WORDS): resp_err = 1, resp_rdata = 0, no memory change.
  - Load: resp_rdata = mem[index], resp_err = 0.
  - Store: for each i with wmask[i] = 1, mem[index] byte i = wdata byte i. Other bytes unchanged. resp_rdata = 0, resp_err = 0.
  - Store with wmask = 0: no change, normal (non-error) response.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err stable until handshake.
  - On resp_ready, go to IDLE with resp_valid = 0 at the next edge. resp_rdata and resp_err are cleared to 0 at the same edge.
  - req_ready is 0 in RESP. Accept and response never overlap in one cycle.
- Latency:
  - Request accepted in cycle N → resp_valid first high in cycle N+1+LATENCY.
  - If resp_ready is held high, the next accept is possible at cycle N+2+LATENCY.
- Backpressure: resp_valid is held indefinitely while resp_ready = 0; the memory is not re-accessed.
- Input changes: req_* inputs changing after acceptance have no effect (latched copy used).
- Ordering:
  - Store then load to the same address returns the stored bytes.
  - There is no read-during-write hazard, because only one access is in flight.
- Reset mid-operation:
  - Asserting rst in WAIT aborts the request and returns to IDLE. A store not yet committed is discarded.
  - Asserting rst in RESP drops the response; any store has already committed.
- Boundaries:
  - Last word (BASE_ADDR + 8*(DEPTH_WORDS-1)) is legal.
  - Address BASE_ADDR + 8*DEPTH_WORDS errors.
  - Address BASE_ADDR - 8 errors (no wrap).

Test Plan:
- Masked store: store addr 0x80001000, wdata 0x1234567887654321, wmask 0xFF, then load the same address → resp_rdata 0x1234567887654321, resp_err 0. Response arrives exactly 3 cycles after accept with LATENCY = 2.
- Partial masks: store 0xAAAAAAAAAAAAAAAA mask 0xFF, then store 0x1122334455667788 mask 0x03, then load → 0xAAAAAAAAAAAA7788. Repeat with mask 0x3C → 0xAAAA3344556677 88 pattern bytes 2..5 = 0x33445566, i.e. 0xAAAA334455667788 after the 0x03 store.
- Backpressure: hold resp_ready = 0 for 5 cycles during a load → resp_valid and resp_rdata stable and req_ready = 0 throughout. Raise resp_ready → IDLE and req_ready = 1 the next cycle.
- Out of range:
  - Load 0x7FFFFFF8 → resp_err 1, rdata 0.
  - Store 0x80002000 (DEPTH_WORDS = 1024) → resp_err 1; a subsequent load of 0x80000000 is unchanged.
  - Load 0x80001FF8 → resp_err 0.
- Reset in WAIT: accept a store of 0xDEADBEEF mask 0xFF to 0x80000010, assert rst on the next cycle → no response. A later load of 0x80000010 returns the prior value.
- Back-to-back: req_valid held high with 4 loads and resp_ready = 1 → each accepted exactly 1+LATENCY+1 cycles apart; the req_ready and resp_valid waveforms never overlap.
